sobol_rng_core: RTL
===================

Name: sobol_rng_core

Overview:
Sobol low-discrepancy sequence generator for one dimension, used by the muxADD stochastic-computing unit. Holds an INWD-bit index counter and feeds it to the least-significant-zero finder. Uses the returned index to select a direction vector and XORs that vector into the output state. Emits one INWD-bit quasi-random number per valid/ready handshake; the direction vectors can be programmed while the block is idle.

Parameters:
INWD, 8, data/counter width (legal values 4, 6, 8, 10; matches `INWD build define)
LOGINWD, $clog2(INWD), width of the LSZ index and of the direction-vector address

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; in IDLE, begin/resume generation
stop  in  1  pulse; in RUN, return to IDLE (count and state retained)
clr  in  1  pulse; zero counter and output state (any state)
dv_wr_en  in  1  direction-vector write strobe (honoured only in IDLE)
dv_wr_idx  in  LOGINWD  vector address, 0..INWD-1 (values >= INWD ignored)
dv_wr_data  in  INWD  vector value
out_valid  out  1  out_data holds a valid sample
out_ready  in  1  consumer accepts sample
out_data  out  INWD  current Sobol sample x_n
period_done  out  1  one-cycle pulse when the sequence wraps
dv_err  out  1  sticky flag: write attempted outside IDLE; cleared by clr or reset

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; cnt=0; x=0; out_valid=0; out_data=0; period_done=0; dv_err=0.
  - V[k] = 1 << (INWD-1-k), the van der Corput default.
- FSM states: IDLE, RUN.
  - IDLE->RUN on start with dv_wr_en=0.
  - RUN->IDLE on stop.
  - start in RUN and stop in IDLE are ignored.
- IDLE:
  - out_valid=0.
  - dv_wr_en with idx<INWD writes V[idx] at the clock edge.
  - If dv_wr_en and start arrive together, the write is applied and start is ignored that cycle.
- RUN:
  - out_valid=1 from the first cycle after start; out_data=x (registered, zero combinational path from inputs).
  - Sample x_0 = 0 after reset/clr.
- Advance: on out_valid & out_ready, next edge sets x <= x ^ V[lsz(cnt)] and cnt <= cnt+1.
  - lsz = index of the least significant 0 of cnt.
  - For cnt all-ones the LSZ finder returns 0, but this case is overridden by wrap (below).
- Backpressure: out_valid & !out_ready holds x and cnt; out_data stays stable.
- Wrap: advancing from cnt = 2^INWD-1 sets cnt <= 0 and x <= 0, and asserts period_done for exactly the following cycle.
  - Period = 2^INWD samples, each value 0..2^INWD-1 exactly once, given linearly independent vectors.
- stop coinciding with a handshake: the advance completes and FSM goes to IDLE. A later start resumes at the new x.
- clr:
  - Highest priority over advance/start/stop: cnt=0, x=0, dv_err=0.
  - FSM unchanged, so clr in RUN continues from x_0 next cycle.
  - V is not touched.
- dv_wr_en in RUN sets dv_err=1; V is unchanged.
- Reset mid-operation: every register returns to its reset value immediately (async). V returns to the defaults.
- Latency: one cycle from handshake to the next sample; one cycle from start to out_valid.

Decomposition:
- Package sobol_pkg:
  - INWD/LOGINWD constants mirroring the `INWD defines.
  - state_t enum {IDLE, RUN}.
  - function default_dv(k) returning 1<<(INWD-1-k).
- Sub-module: instantiate the codebase's existing least-significant-zero finder (LSZ), with cnt driving its input and its index output driving the V mux.
- Direction-vector register file, FSM, counter and state register stay inline in sobol_rng_core.

Test Plan:
- Default vectors, INWD=4, reset, start, out_ready=1 -> out_data sequence 0,8,12,4,6,14,10,2,3,... over 16 samples, each of 0..15 exactly once. period_done pulses once after the 16th handshake, then out_data=0.
- Backpressure: hold out_ready=0 for 5 cycles after sample 8 -> out_data stays 8 with out_valid=1 throughout; the next accepted sample is 12.
- Program V[0]=4'b0001, V[1]=4'b0010, V[2]=4'b0100, V[3]=4'b1000 in IDLE, then start -> sequence 0,1,3,2,6,7,5,4,... Also issue dv_wr_en during RUN -> dv_err=1 and the sequence is unaffected.
- stop and handshake in the same cycle at x=12 -> FSM IDLE, out_valid=0. A later start presents 4 first.
- clr in RUN at x=6 -> next cycle out_data=0, cnt=0, dv_err=0. The following sample is V[0].
- Assert rst_n=0 asynchronously mid-RUN (between edges) -> out_valid and out_data go to 0 immediately, and the default vectors are restored.

Source files
------------

// File: rtl/sobol_pkg.sv
// Shared constants, FSM state type and default direction vectors for the
// one-dimensional Sobol generator.
package sobol_pkg;

   localparam int INWD    = 8;
   localparam int LOGINWD = $clog2(INWD);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Van der Corput direction vector for index k of a w-bit generator.
   function automatic logic [31:0] default_dv(input int k, input int w = INWD);
      return 32'(1) << (w - 1 - k);
   endfunction

endpackage

// File: rtl/sobol_rng_core_lsz.sv
// Least-significant-zero finder: returns the bit index of the lowest 0 in
// value, or 0 when value is all ones.
module lsz #(
   parameter int W    = 8,
   parameter int LOGW = $clog2(W)
) (
   input  logic [W-1:0]    value,
   output logic [LOGW-1:0] idx
);

   // Scan from the top so the lowest zero found is the one that sticks.
   always_comb begin
      idx = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!value[i]) begin
            idx = LOGW'(i);
         end
      end
   end

endmodule

// File: rtl/sobol_rng_core.sv
// One-dimensional Sobol sequence generator with programmable direction
// vectors and a valid/ready output handshake.
module sobol_rng_core #(
   parameter int INWD    = sobol_pkg::INWD,
   parameter int LOGINWD = $clog2(INWD)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               clr,
   input  logic               dv_wr_en,
   input  logic [LOGINWD-1:0] dv_wr_idx,
   input  logic [INWD-1:0]    dv_wr_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INWD-1:0]    out_data,
   output logic               period_done,
   output logic               dv_err
);

   import sobol_pkg::*;

   state_t              state;
   state_t              state_nxt;
   logic [INWD-1:0]     dv [INWD];
   logic [INWD-1:0]     cnt;
   logic [INWD-1:0]     x;
   logic [LOGINWD-1:0]  lsz_idx;
   logic                fire;
   logic                cnt_wrap;
   logic                dv_wr_ok;

   lsz #(
      .W    (INWD),
      .LOGW (LOGINWD)
   ) u_lsz (
      .value (cnt),
      .idx   (lsz_idx)
   );

   assign out_valid = (state == RUN);
   assign out_data  = x;
   assign fire      = out_valid & out_ready;
   assign cnt_wrap  = &cnt;
   assign dv_wr_ok  = dv_wr_en && (state == IDLE)
                      && ({1'b0, dv_wr_idx} < (LOGINWD + 1)'(INWD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // clr freezes the FSM for its cycle; a write alongside start wins over start.
   always_comb begin
      state_nxt = state;
      if (!clr) begin
         case (state)
            IDLE: if (start && !dv_wr_en) state_nxt = RUN;
            RUN:  if (stop)               state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < INWD; k++) begin
            dv[k] <= INWD'(default_dv(k, INWD));
         end
      end else if (dv_wr_ok) begin
         dv[dv_wr_idx] <= dv_wr_data;
      end
   end

   // The all-ones count wraps to x_0 instead of using the LSZ result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         x           <= '0;
         period_done <= 1'b0;
         dv_err      <= 1'b0;
      end else begin
         period_done <= 1'b0;
         if (clr) begin
            cnt    <= '0;
            x      <= '0;
            dv_err <= 1'b0;
         end else begin
            if (fire) begin
               if (cnt_wrap) begin
                  cnt         <= '0;
                  x           <= '0;
                  period_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
                  x   <= x ^ dv[lsz_idx];
               end
            end
            if (dv_wr_en && (state == RUN)) begin
               dv_err <= 1'b1;
            end
         end
      end
   end

endmodule
